rx_frame_dispatcher: RTL and testbench

Sits on the CLK_RX byte stream between the MAC receive interface and the protocol parsers, including the ARP responder and the IPv4 receive path. It buffers each frame's 14-byte Ethernet header in a fixed-delay pipeline and classifies the frame by destination MAC and EtherType. It then forwards the whole frame, header included, to exactly one consumer or drops it. Saturating statistics counters record total, dropped and runt frames.

---
 rtl/rx_frame_dispatcher_if.sv | 27 ++
 rtl/rx_frame_dispatcher.sv | 183 ++++++++++++++++++
 tb/tb_rx_frame_dispatcher.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_frame_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module      : rx_frame_dispatcher_if
// Description : Receive byte stream in, per-consumer busy/valid and shared
//               delayed byte stream out.
// Revision    : 1.0 - initial release
// ============================================================================
interface rx_frame_dispatcher_if;
   logic       DATA_VALID_RX;
   logic [7:0] DATA_RX;
   logic       ARP_BUSY;
   logic       IP_BUSY;
   logic [7:0] OUT_DATA;
   logic       ARP_VALID;
   logic       IP_VALID;

   modport master (
      output DATA_VALID_RX, DATA_RX, ARP_BUSY, IP_BUSY,
      input  OUT_DATA, ARP_VALID, IP_VALID
   );

   modport slave (
      input  DATA_VALID_RX, DATA_RX, ARP_BUSY, IP_BUSY,
      output OUT_DATA, ARP_VALID, IP_VALID
   );
endinterface
`default_nettype wire

// File: rtl/rx_frame_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : rx_frame_dispatcher
// Description : Delays each frame by its header length, classifies it by
//               DA/EtherType and forwards it to ARP, IPv4 or nowhere.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_dispatcher #(
   parameter int CNT_W   = 16,
   parameter int HDR_LEN = 14
) (
   input  logic                 CLK_RX,
   input  logic                 ARESET,
   input  logic [47:0]          MY_MAC,
   rx_frame_dispatcher_if.slave rx,
   output logic [CNT_W-1:0]     FRAME_CNT,
   output logic [CNT_W-1:0]     DROP_CNT,
   output logic [CNT_W-1:0]     RUNT_CNT
);
   localparam logic [1:0] c_ST_WAIT_GAP = 2'd0;
   localparam logic [1:0] c_ST_IDLE     = 2'd1;
   localparam logic [1:0] c_ST_HDR      = 2'd2;
   localparam logic [1:0] c_ST_BODY     = 2'd3;

   localparam logic [1:0] c_SEL_NONE = 2'd0;
   localparam logic [1:0] c_SEL_ARP  = 2'd1;
   localparam logic [1:0] c_SEL_IP   = 2'd2;

   localparam logic [3:0]       c_LAST_HDR = 4'(HDR_LEN - 1);
   localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic [3:0]         r_cnt;
   logic               w_frame_start;
   logic               w_in_valid;
   logic               w_classify;
   logic               w_runt;

   logic [7:0]         r_pipe_data [HDR_LEN];
   logic [HDR_LEN-1:0] r_pipe_valid;
   logic [HDR_LEN-1:0] r_pipe_sof;

   logic [47:0]        w_da;
   logic [15:0]        w_ethertype;
   logic               w_da_ok;
   logic [1:0]         w_sel_class;
   logic               w_exit_sof;
   logic [1:0]         w_cur_sel;

   logic [1:0]         r_sel_pending;
   logic [1:0]         r_out_sel;
   logic [7:0]         r_out_data;
   logic               r_arp_valid;
   logic               r_ip_valid;
   logic [CNT_W-1:0]   r_frame_cnt;
   logic [CNT_W-1:0]   r_drop_cnt;
   logic [CNT_W-1:0]   r_runt_cnt;

   always_ff @(posedge CLK_RX) begin
      if (ARESET) begin
         r_state <= c_ST_WAIT_GAP;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_frame_start)
            r_cnt <= 4'd1;
         else if (r_state == c_ST_HDR && rx.DATA_VALID_RX && r_cnt != c_LAST_HDR)
            r_cnt <= r_cnt + 4'd1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_WAIT_GAP: if (!rx.DATA_VALID_RX) w_state_nxt = c_ST_IDLE;
         c_ST_IDLE:     if (rx.DATA_VALID_RX)  w_state_nxt = c_ST_HDR;
         c_ST_HDR: begin
            if (!rx.DATA_VALID_RX)
               w_state_nxt = c_ST_IDLE;
            else if (r_cnt == c_LAST_HDR)
               w_state_nxt = c_ST_BODY;
         end
         c_ST_BODY:     if (!rx.DATA_VALID_RX) w_state_nxt = c_ST_IDLE;
         default:       w_state_nxt = c_ST_WAIT_GAP;
      endcase
   end

   always_comb begin
      w_frame_start = 1'b0;
      w_in_valid    = 1'b0;
      w_classify    = 1'b0;
      w_runt        = 1'b0;
      case (r_state)
         c_ST_IDLE: begin
            w_frame_start = rx.DATA_VALID_RX;
            w_in_valid    = rx.DATA_VALID_RX;
         end
         c_ST_HDR: begin
            w_in_valid = rx.DATA_VALID_RX;
            w_classify = rx.DATA_VALID_RX && (r_cnt == c_LAST_HDR);
            w_runt     = !rx.DATA_VALID_RX;
         end
         c_ST_BODY: w_in_valid = rx.DATA_VALID_RX;
         default: ;
      endcase
   end

   always_ff @(posedge CLK_RX) begin
      if (ARESET) begin
         r_pipe_valid <= '0;
         r_pipe_sof   <= '0;
         for (int i = 0; i < HDR_LEN; i++) r_pipe_data[i] <= 8'd0;
      end else begin
         r_pipe_valid   <= {r_pipe_valid[HDR_LEN-2:0], w_in_valid};
         r_pipe_sof     <= {r_pipe_sof[HDR_LEN-2:0], w_frame_start};
         r_pipe_data[0] <= rx.DATA_RX;
         for (int i = 1; i < HDR_LEN; i++) r_pipe_data[i] <= r_pipe_data[i-1];
      end
   end

   // While byte 13 is on the input, bytes 0..12 sit in stages 12..0.
   assign w_da        = {r_pipe_data[HDR_LEN-2], r_pipe_data[HDR_LEN-3], r_pipe_data[HDR_LEN-4],
                         r_pipe_data[HDR_LEN-5], r_pipe_data[HDR_LEN-6], r_pipe_data[HDR_LEN-7]};
   assign w_ethertype = {r_pipe_data[0], rx.DATA_RX};
   assign w_da_ok     = (w_da == MY_MAC) || (w_da == 48'hFFFF_FFFF_FFFF);

   always_comb begin
      w_sel_class = c_SEL_NONE;
      if (w_da_ok) begin
         if (w_ethertype == 16'h0806 && !rx.ARP_BUSY)
            w_sel_class = c_SEL_ARP;
         else if (w_ethertype == 16'h0800 && !rx.IP_BUSY)
            w_sel_class = c_SEL_IP;
      end
   end

   assign w_exit_sof = r_pipe_valid[HDR_LEN-1] & r_pipe_sof[HDR_LEN-1];
   assign w_cur_sel  = w_exit_sof ? r_sel_pending : r_out_sel;

   always_ff @(posedge CLK_RX) begin
      if (ARESET) begin
         r_sel_pending <= c_SEL_NONE;
         r_out_sel     <= c_SEL_NONE;
         r_out_data    <= 8'd0;
         r_arp_valid   <= 1'b0;
         r_ip_valid    <= 1'b0;
      end else begin
         if (w_classify)
            r_sel_pending <= w_sel_class;
         else if (w_exit_sof)
            r_sel_pending <= c_SEL_NONE;
         if (w_exit_sof)
            r_out_sel <= r_sel_pending;
         r_out_data  <= r_pipe_data[HDR_LEN-1];
         r_arp_valid <= r_pipe_valid[HDR_LEN-1] && (w_cur_sel == c_SEL_ARP);
         r_ip_valid  <= r_pipe_valid[HDR_LEN-1] && (w_cur_sel == c_SEL_IP);
      end
   end

   always_ff @(posedge CLK_RX) begin
      if (ARESET) begin
         r_frame_cnt <= '0;
         r_drop_cnt  <= '0;
         r_runt_cnt  <= '0;
      end else begin
         if (w_frame_start && r_frame_cnt != '1)
            r_frame_cnt <= r_frame_cnt + c_CNT_ONE;
         if (w_classify && w_sel_class == c_SEL_NONE && r_drop_cnt != '1)
            r_drop_cnt <= r_drop_cnt + c_CNT_ONE;
         if (w_runt && r_runt_cnt != '1)
            r_runt_cnt <= r_runt_cnt + c_CNT_ONE;
      end
   end

   assign rx.OUT_DATA  = r_out_data;
   assign rx.ARP_VALID = r_arp_valid;
   assign rx.IP_VALID  = r_ip_valid;
   assign FRAME_CNT    = r_frame_cnt;
   assign DROP_CNT     = r_drop_cnt;
   assign RUNT_CNT     = r_runt_cnt;
endmodule
`default_nettype wire

// File: tb/tb_rx_frame_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_frame_dispatcher
// Description : Directed frames into rx_frame_dispatcher with checked routing,
//               latency, data and counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_frame_dispatcher;
   logic        CLK_RX = 1'b0;
   logic        ARESET = 1'b1;
   logic [47:0] MY_MAC = 48'h02_00_00_00_00_01;
   logic [15:0] FRAME_CNT, DROP_CNT, RUNT_CNT;

   rx_frame_dispatcher_if rx ();

   rx_frame_dispatcher #(.CNT_W(16), .HDR_LEN(14)) dut (
      .CLK_RX    (CLK_RX),
      .ARESET    (ARESET),
      .MY_MAC    (MY_MAC),
      .rx        (rx),
      .FRAME_CNT (FRAME_CNT),
      .DROP_CNT  (DROP_CNT),
      .RUNT_CNT  (RUNT_CNT)
   );

   always #5 CLK_RX = ~CLK_RX;

   int cyc = 0;
   always @(posedge CLK_RX) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   logic [7:0] exp_frame [128];
   logic       mon_en        = 1'b0;
   logic       arp_d         = 1'b0;
   logic       ip_d          = 1'b0;
   int         arp_cyc_tot   = 0;
   int         ip_cyc_tot    = 0;
   int         arp_rise_tot  = 0;
   int         ip_rise_tot   = 0;
   int         data_err_tot  = 0;
   int         overlap_tot   = 0;
   int         last_rise_cyc = 0;
   int         mon_idx       = 0;
   int         sof_sample_cyc = 0;

   // Output monitor: every valid byte is compared to the current reference frame.
   always @(negedge CLK_RX) begin
      if (mon_en && !ARESET) begin
         if (rx.ARP_VALID || rx.IP_VALID) begin
            if (!(arp_d || ip_d)) begin
               last_rise_cyc = cyc;
               mon_idx       = 0;
            end
            if (rx.OUT_DATA !== exp_frame[mon_idx]) data_err_tot++;
            if (mon_idx < 127) mon_idx++;
         end
         if (rx.ARP_VALID) arp_cyc_tot++;
         if (rx.IP_VALID)  ip_cyc_tot++;
         if (rx.ARP_VALID && !arp_d) arp_rise_tot++;
         if (rx.IP_VALID && !ip_d)   ip_rise_tot++;
         if (rx.ARP_VALID && rx.IP_VALID) overlap_tot++;
      end
      arp_d = rx.ARP_VALID;
      ip_d  = rx.IP_VALID;
   end

   task automatic build_frame(input logic [47:0] da, input logic [15:0] et, input int seed);
      for (int i = 0; i < 128; i++) exp_frame[i] = 8'(i * 13 + seed);
      for (int i = 0; i < 6; i++) begin
         exp_frame[i]     = da[47-8*i -: 8];
         exp_frame[6 + i] = 8'(8'hA0 + i);
      end
      exp_frame[12] = et[15:8];
      exp_frame[13] = et[7:0];
   endtask

   task automatic drive_byte(input logic [7:0] b, input logic busy);
      rx.DATA_VALID_RX = 1'b1;
      rx.DATA_RX       = b;
      rx.ARP_BUSY      = busy;
      rx.IP_BUSY       = busy;
      @(posedge CLK_RX);
      #1;
   endtask

   // busy_mode: 0 never busy, 1 busy only on byte 13, 2 busy on bytes after 13
   task automatic send_range(input int lo, input int hi, input int busy_mode);
      for (int i = lo; i < hi; i++) begin
         if (i == 0) sof_sample_cyc = cyc + 1;
         drive_byte(exp_frame[i], (busy_mode == 1 && i == 13) || (busy_mode == 2 && i > 13));
      end
   endtask

   task automatic gap(input int n);
      rx.DATA_VALID_RX = 1'b0;
      rx.ARP_BUSY      = 1'b0;
      rx.IP_BUSY       = 1'b0;
      repeat (n) begin
         @(posedge CLK_RX);
         #1;
      end
   endtask

   task automatic do_reset();
      ARESET = 1'b1;
      gap(2);
      ARESET = 1'b0;
      gap(2);
   endtask

   int b_arp, b_ip, b_arise, b_irise, b_err;
   task automatic snap();
      b_arp   = arp_cyc_tot;
      b_ip    = ip_cyc_tot;
      b_arise = arp_rise_tot;
      b_irise = ip_rise_tot;
      b_err   = data_err_tot;
   endtask

   initial begin
      rx.DATA_VALID_RX = 1'b0;
      rx.DATA_RX       = 8'd0;
      rx.ARP_BUSY      = 1'b0;
      rx.IP_BUSY       = 1'b0;
      build_frame(48'hFFFF_FFFF_FFFF, 16'h0806, 0);
      repeat (3) @(posedge CLK_RX);
      #1;
      chk("rst_out_data",  rx.OUT_DATA,  0);
      chk("rst_arp_valid", rx.ARP_VALID, 0);
      chk("rst_ip_valid",  rx.IP_VALID,  0);
      chk("rst_frame_cnt", FRAME_CNT,    0);
      chk("rst_drop_cnt",  DROP_CNT,     0);
      chk("rst_runt_cnt",  RUNT_CNT,     0);
      ARESET = 1'b0;
      mon_en = 1'b1;
      gap(2);

      // 1: broadcast ARP, 42 bytes
      snap();
      build_frame(48'hFFFF_FFFF_FFFF, 16'h0806, 1);
      send_range(0, 42, 0);
      gap(20);
      chk("t1_latency",   last_rise_cyc, sof_sample_cyc + 14);
      chk("t1_arp_cyc",   arp_cyc_tot - b_arp, 42);
      chk("t1_ip_cyc",    ip_cyc_tot - b_ip, 0);
      chk("t1_data",      data_err_tot - b_err, 0);
      chk("t1_frame_cnt", FRAME_CNT, 1);
      chk("t1_drop_cnt",  DROP_CNT, 0);

      // 2: unicast IPv4, 60 bytes, busy raised after classification
      do_reset();
      snap();
      build_frame(48'h02_00_00_00_00_01, 16'h0800, 2);
      send_range(0, 60, 2);
      gap(20);
      chk("t2_ip_cyc",    ip_cyc_tot - b_ip, 60);
      chk("t2_arp_cyc",   arp_cyc_tot - b_arp, 0);
      chk("t2_data",      data_err_tot - b_err, 0);
      chk("t2_latency",   last_rise_cyc, sof_sample_cyc + 14);

      // 3: wrong DA, then unknown EtherType
      do_reset();
      snap();
      build_frame(48'h02_00_00_00_00_02, 16'h0800, 3);
      send_range(0, 60, 0);
      gap(1);
      build_frame(48'h02_00_00_00_00_01, 16'h86DD, 4);
      send_range(0, 60, 0);
      gap(20);
      chk("t3_valid_cyc", (arp_cyc_tot - b_arp) + (ip_cyc_tot - b_ip), 0);
      chk("t3_drop_cnt",  DROP_CNT, 2);
      chk("t3_frame_cnt", FRAME_CNT, 2);

      // 4: 10-byte runt, then ARP after a 1-cycle gap
      do_reset();
      snap();
      build_frame(48'hFFFF_FFFF_FFFF, 16'h0806, 5);
      send_range(0, 10, 0);
      gap(1);
      build_frame(48'hFFFF_FFFF_FFFF, 16'h0806, 6);
      send_range(0, 42, 0);
      gap(20);
      chk("t4_runt_cnt",  RUNT_CNT, 1);
      chk("t4_arp_cyc",   arp_cyc_tot - b_arp, 42);
      chk("t4_arp_rise",  arp_rise_tot - b_arise, 1);
      chk("t4_data",      data_err_tot - b_err, 0);
      chk("t4_invariant", FRAME_CNT,
          (arp_rise_tot - b_arise) + (ip_rise_tot - b_irise) + DROP_CNT + RUNT_CNT);

      // 5: back-to-back ARP, second sees ARP_BUSY at byte 13
      do_reset();
      snap();
      build_frame(48'hFFFF_FFFF_FFFF, 16'h0806, 7);
      send_range(0, 42, 0);
      gap(1);
      send_range(0, 42, 1);
      gap(20);
      chk("t5_arp_cyc",   arp_cyc_tot - b_arp, 42);
      chk("t5_arp_rise",  arp_rise_tot - b_arise, 1);
      chk("t5_drop_cnt",  DROP_CNT, 1);
      chk("t5_data",      data_err_tot - b_err, 0);

      // 6: reset at byte 20 of an IPv4 frame
      do_reset();
      build_frame(48'h02_00_00_00_00_01, 16'h0800, 8);
      send_range(0, 20, 0);
      chk("t6_pre_ip_valid", rx.IP_VALID, 1);
      ARESET = 1'b1;
      drive_byte(exp_frame[20], 1'b0);
      ARESET = 1'b0;
      chk("t6_rst_ip_valid", rx.IP_VALID, 0);
      chk("t6_rst_out_data", rx.OUT_DATA, 0);
      chk("t6_rst_frame",    FRAME_CNT, 0);
      send_range(21, 60, 0);
      gap(2);
      chk("t6_ignored_frame", FRAME_CNT, 0);
      snap();
      build_frame(48'h02_00_00_00_00_01, 16'h0800, 9);
      send_range(0, 60, 0);
      gap(20);
      chk("t6_ip_cyc",    ip_cyc_tot - b_ip, 60);
      chk("t6_data",      data_err_tot - b_err, 0);
      chk("t6_frame_cnt", FRAME_CNT, 1);
      chk("no_overlap",   overlap_tot, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
